// File: rtl/sonar_scan_ctrl.sv
// sonar_scan_ctrl: round-robin trigger/echo-timing engine shared across several
// HC-SR04-class rangers, emitting raw echo width per sensor with a valid strobe.
module sonar_scan_ctrl #(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int HOLDOFF_CYCLES = 3000000,
    parameter int CNT_W          = 22,
    parameter int ID_W           = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   valid,
    output logic [ID_W-1:0]        sensor_id,
    output logic [CNT_W-1:0]       echo_cycles,
    output logic                   timeout,
    output logic                   busy
);
    typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    state_t                 state, state_n;
    logic [NUM_SENSORS-1:0] echo_m, echo_s;
    logic [ID_W-1:0]        cur_id, id_n, pick;
    logic [CNT_W-1:0]       cnt, cnt_n, width, width_n, res_width;
    logic                   sel, sel_prev, rise, fall, at_timeout, found, result, res_to;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    assign sel        = echo_s[cur_id];
    assign rise       = sel & ~sel_prev;
    assign fall       = ~sel & sel_prev;
    assign at_timeout = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);
    assign busy       = state != IDLE;

    // cur_id doubles as the last-served sensor; descending loop lets the nearest hit win
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NUM_SENSORS; i >= 1; i--) begin
            if (sensor_mask[(int'(cur_id) + i) % NUM_SENSORS]) begin
                pick  = ID_W'((int'(cur_id) + i) % NUM_SENSORS);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = sat_inc(cnt);
        width_n   = width;
        id_n      = cur_id;
        result    = 1'b0;
        res_to    = 1'b0;
        res_width = '0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = (enable && |sensor_mask) ? SELECT : IDLE;
            end
            SELECT: begin
                cnt_n   = '0;
                width_n = '0;
                id_n    = found ? pick : cur_id;
                state_n = found ? TRIG : IDLE;
            end
            TRIG: begin
                if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (at_timeout) begin
                    result = 1'b1;
                    res_to = 1'b1;
                end else if (rise) begin
                    width_n = CNT_W'(1);
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                width_n = sat_inc(width);
                if (fall) begin
                    result    = 1'b1;
                    res_width = width;
                end else if (at_timeout) begin
                    result    = 1'b1;
                    res_to    = 1'b1;
                    res_width = sat_inc(width);
                end
            end
            HOLDOFF: begin
                if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = enable ? SELECT : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (result) begin
            cnt_n   = '0;
            state_n = HOLDOFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            echo_m      <= '0;
            echo_s      <= '0;
            sel_prev    <= 1'b0;
            cnt         <= '0;
            width       <= '0;
            cur_id      <= ID_W'(NUM_SENSORS - 1);
            trigger     <= '0;
            valid       <= 1'b0;
            sensor_id   <= '0;
            echo_cycles <= '0;
            timeout     <= 1'b0;
        end else begin
            state    <= state_n;
            echo_m   <= echo;
            echo_s   <= echo_m;
            sel_prev <= sel;
            cnt      <= cnt_n;
            width    <= width_n;
            cur_id   <= id_n;
            trigger  <= (state_n == TRIG) ? NUM_SENSORS'(1) << id_n : '0;
            valid    <= result;
            if (result) begin
                sensor_id   <= cur_id;
                echo_cycles <= res_width;
                timeout     <= res_to;
            end
        end
    end
endmodule
